sprite_line_buffer: RTL
=======================

Name: sprite_line_buffer

Overview:
- Ping-pong line buffer directly downstream of sprite_engine.
- Captures the pixel writes (column, RGB565 data, write enable) that the engine produces for the next scanline.
- Streams the completed line to the VGA compositor during the current scanline, read-clearing each pixel as it goes.
- Issues the per-line sprite_start pulse that launches the engine and swaps banks at end of line.

Parameters:
- LINE_W, 640, pixels per line and depth of each bank.
- PIX_W, 16, pixel width (RGB565).
- TRANSP, 16'h0000, transparent key; also the clear value.
- H_SWAP, 11'd1599, hcount value on which banks swap (last cycle of the 800-pixel line, 2 clk/pixel).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- hcount  in  11  VGA horizontal counter; pixel x = hcount[10:1].
- vcount  in  10  VGA vertical counter.
- sprite_start  out  1  one-cycle pulse that starts the engine for the next line.
- wr_col  in  10  engine pixel column (sprite_pixel_col).
- wr_data  in  16  engine pixel data (sprite_pixel_data).
- wr_en  in  1  engine write strobe (wren_pixel_draw).
- eng_done  in  1  engine line-complete level (done).
- pix_data  out  16  display pixel for the current x.
- pix_opaque  out  1  pix_data is valid and not TRANSP; the compositor selects the sprite over background when high.
- overrun  out  1  sticky: a swap occurred before eng_done.

Behaviour:
- Storage: two banks of LINE_W x PIX_W. draw_sel selects the bank the engine writes; the other bank is the display bank.
- Reset: draw_sel=0, state=IDLE, sprite_start=0, pix_data=0, pix_opaque=0, overrun=0, primed=0. RAM contents are not reset.
- Swap event: hcount==H_SWAP.
  - Toggles draw_sel.
  - sprite_start pulses high on the following cycle, exactly once per line, including vblank lines.
  - primed (2-bit saturating) increments.
- Write-side FSM:
  - IDLE: on sprite_start go to DRAW.
  - DRAW: accept writes. On eng_done go to DONE. If a swap occurs while in DRAW, set overrun and stay in DRAW; the new sprite_start restarts the line.
  - DONE: on sprite_start go to DRAW.
  - Swap and sprite_start in the same line boundary always take priority over eng_done.
- Write accept: wr_en && state==DRAW && wr_col<LINE_W. The write lands in the draw bank at wr_col with data wr_data.
  - Writes in IDLE/DONE, or with wr_col>=LINE_W, are dropped silently.
  - Later writes to the same column overwrite earlier ones (last-written wins).
  - A write in the same cycle as the swap goes to the pre-swap bank.
- Display/read-clear, every line regardless of vcount:
  - Even hcount with x<LINE_W: read display bank[x].
  - The following odd cycle: write TRANSP to display bank[x].
  - Result: the bank is empty by the time it becomes the draw bank.
- Output latency: pix_data is registered 2 cycles after the even hcount that addresses x, and held for 2 cycles.
- pix_opaque=1 iff vcount<480, x<LINE_W, primed==2, and data!=TRANSP; otherwise pix_opaque=0 and pix_data=0.
  - The primed gate hides uncleared RAM until both banks have been swept once after reset.
- Reset mid-line: behaves as above. No partial writes occur after reset is asserted; a swap occurring while reset is high is ignored.
- overrun clears only on reset.

Decomposition:
- Shared package sprite_pkg:
  - LINE_W, PIX_W, TRANSP, H_SWAP, H_TOTAL=1600, V_ACTIVE=480.
  - typedef pixel_t (logic [15:0]).
  - enum lb_state_t {IDLE, DRAW, DONE}.
- Sub-module sprite_line_bank: one bank with one write port (engine) and one read/write port (display read-clear), instantiated twice.
  - Inferred M10K, 1-cycle registered read.
  - Bank-select muxing lives in the top level.

Test Plan:
- Reset, then run 3 lines with no writes -> one sprite_start pulse per line, at the cycle after each hcount==1599; pix_opaque=0 throughout; overrun=0.
- After priming, write col=5 data=16'hF800 in DRAW, assert eng_done, then swap -> on the next line pix_data=16'hF800 and pix_opaque=1 for exactly the 2 cycles starting 2 clk after hcount=10; all other pixels read 0.
- Same line replayed with no new writes -> col 5 reads TRANSP (read-clear verified) and pix_opaque=0.
- Two writes to col 100 (16'h07E0, then 16'h001F) in one line -> display shows 16'h001F. A write with wr_col=700 -> dropped, with no alias at col 60.
- Hold eng_done=0 across a swap -> overrun=1 and stays 1 across later lines until reset; writes after eng_done (state DONE) are dropped.
- vcount=500 with data written -> pix_opaque=0, yet the bank is still cleared. Assert reset at hcount=800 mid-line -> all outputs 0 next cycle and primed=0.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite line buffer and its banks.
// Holds line geometry, the transparent/clear key and the write-side
// FSM state encoding.
package sprite_pkg;

  localparam int           LINE_W   = 640;
  localparam int           PIX_W    = 16;
  localparam int           COL_W    = 10;
  localparam int           H_TOTAL  = 1600;
  localparam int           V_ACTIVE = 480;

  localparam logic [15:0]  TRANSP   = 16'h0000;
  localparam logic [10:0]  H_SWAP   = 11'd1599;

  // Width-matched compare limits for 10-bit column / row values.
  localparam logic [9:0]   LINE_END = 10'd640;
  localparam logic [9:0]   V_END    = 10'd480;

  // Number of swaps after reset before display data can be trusted.
  localparam logic [1:0]   PRIMED_FULL = 2'd2;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    DONE
  } lb_state_t;

endpackage

// File: rtl/sprite_line_bank.sv
// One LINE_W x PIX_W line bank: engine write port plus display read/clear port.
// Latency: rd_data is registered one cycle after rd_en; no flow control, every
// strobe is accepted in its cycle.
// Ports: clk; wr_en/wr_addr/wr_data (engine write); rd_en (read), clr_en
// (write TRANSP), rd_addr shared by both display operations; rd_data.
module sprite_line_bank
  import sprite_pkg::*;
(
  input  logic             clk,
  input  logic             wr_en,
  input  logic [COL_W-1:0] wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic             clr_en,
  input  logic [COL_W-1:0] rd_addr,
  output logic [PIX_W-1:0] rd_data
);

  pixel_t mem [LINE_W];

  // Contents are deliberately not reset; the top level hides stale data
  // until both banks have been swept.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (clr_en) begin
      mem[rd_addr] <= TRANSP;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sprite_line_buffer.sv
// Ping-pong sprite line buffer between sprite_engine and the VGA compositor.
// Latency: pix_data/pix_opaque appear 2 clk after the even hcount addressing x,
// held 2 clk; engine writes are accepted or dropped in their cycle, never stalled.
// Ports: clk, reset (sync, high); hcount/vcount timing; wr_col/wr_data/wr_en and
// eng_done from the engine; sprite_start to the engine; pix_data/pix_opaque to
// the compositor; overrun sticky status.
module sprite_line_buffer
  import sprite_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output logic        sprite_start,
  input  logic [9:0]  wr_col,
  input  logic [15:0] wr_data,
  input  logic        wr_en,
  input  logic        eng_done,
  output logic [15:0] pix_data,
  output logic        pix_opaque,
  output logic        overrun
);

  lb_state_t   state;
  lb_state_t   state_nxt;
  logic        draw_sel;
  logic [1:0]  primed;

  logic [9:0]  pix_x;
  logic        in_line;
  logic        swap;
  logic        rd_cyc;
  logic        clr_cyc;
  logic        wr_acc;

  logic        rd_sel_q;
  logic        vld_q;
  logic [15:0] q0;
  logic [15:0] q1;
  logic [15:0] q_sel;
  logic        show;

  assign pix_x   = hcount[10:1];
  assign in_line = (pix_x < LINE_END);

  // A swap landing while reset is high must not disturb the reset state.
  assign swap    = (hcount == H_SWAP) && !reset;

  // Even half of each pixel reads the display bank, odd half clears it.
  assign rd_cyc  = !hcount[0] && in_line;
  assign clr_cyc = hcount[0] && in_line && !reset;

  // Same-cycle-as-swap writes use the current draw_sel, i.e. the pre-swap bank.
  assign wr_acc  = wr_en && (state == DRAW) && (wr_col < LINE_END) && !reset;

  sprite_line_bank u_bank0 (
    .clk     (clk),
    .wr_en   (wr_acc && !draw_sel),
    .wr_addr (wr_col),
    .wr_data (wr_data),
    .rd_en   (rd_cyc && draw_sel),
    .clr_en  (clr_cyc && draw_sel),
    .rd_addr (pix_x),
    .rd_data (q0)
  );

  sprite_line_bank u_bank1 (
    .clk     (clk),
    .wr_en   (wr_acc && draw_sel),
    .wr_addr (wr_col),
    .wr_data (wr_data),
    .rd_en   (rd_cyc && !draw_sel),
    .clr_en  (clr_cyc && !draw_sel),
    .rd_addr (pix_x),
    .rd_data (q1)
  );

  assign q_sel = rd_sel_q ? q1 : q0;
  assign show  = vld_q && (q_sel != TRANSP);

  // Line boundary (sprite_start or swap) wins over eng_done so a late engine
  // is restarted rather than marked complete.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (sprite_start) state_nxt = DRAW;
      DRAW: begin
        if (sprite_start || swap) state_nxt = DRAW;
        else if (eng_done)        state_nxt = DONE;
      end
      DONE: if (sprite_start) state_nxt = DRAW;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      draw_sel     <= 1'b0;
      primed       <= 2'd0;
      sprite_start <= 1'b0;
      overrun      <= 1'b0;
      vld_q        <= 1'b0;
      rd_sel_q     <= 1'b0;
      pix_data     <= '0;
      pix_opaque   <= 1'b0;
    end else begin
      state        <= state_nxt;
      sprite_start <= swap;

      if (swap) begin
        draw_sel <= ~draw_sel;
        if (primed != PRIMED_FULL) begin
          primed <= primed + 2'd1;
        end
        if (state == DRAW) begin
          overrun <= 1'b1;
        end
      end

      // Qualifiers are sampled alongside the RAM read so they line up with
      // the bank output and stay stable across the two-cycle pixel.
      if (!hcount[0]) begin
        vld_q    <= in_line && (vcount < V_END) && (primed == PRIMED_FULL);
        rd_sel_q <= ~draw_sel;
      end

      pix_opaque <= show;
      pix_data   <= show ? q_sel : '0;
    end
  end

endmodule
